cc_tag_ctl: RTL

- Sequencer and arbiter in front of one cc1 tag array bank (all ways share the read and write ports).
- Runs the post-reset init sweep and on-demand flush sweeps over every set.
- Shares the single tag write port between snoop invalidates and line fills, and gates lookups during sweeps.
- Collects expunged (victim) line addresses into a small FIFO toward the writeback path.

---
 rtl/cc_tag_ctl_if.sv | 49 ++++
 rtl/cc_tag_ctl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cc_tag_ctl_if.sv
// Request/response bundle around the cc1 tag sequencer.
//   slave  : the cc_tag_ctl side (accepts lk/fl/inv/flush, drives the tag array, sources
//            the expunge stream).
//   master : the requester / tag-array / writeback side.
// Signals:
//   lk_*      lookup request and accept; fl_* fill request and grant;
//   inv_*     snoop invalidate request and grant; flush_req/busy sweep control/status;
//   tag_*     tag array read/write/init controls and the array's expunge report;
//   exp_*     expunge FIFO head toward the writeback path.
interface cc_tag_ctl_if;
  logic        lk_valid;
  logic [36:0] lk_addr;
  logic        lk_ready;
  logic        fl_valid;
  logic [36:0] fl_addr;
  logic        fl_ready;
  logic        inv_valid;
  logic [36:0] inv_addr;
  logic        inv_ready;
  logic        flush_req;
  logic        busy;
  logic        tag_read_clkEn;
  logic [36:0] tag_read_addr;
  logic [36:0] tag_write_addr;
  logic        tag_write_wen;
  logic        tag_invalidate;
  logic        tag_init;
  logic        tag_exp_en;
  logic [36:0] tag_exp_addr;
  logic        exp_valid;
  logic [36:0] exp_addr;
  logic        exp_ready;

  modport slave (
    input  lk_valid, lk_addr, fl_valid, fl_addr, inv_valid, inv_addr, flush_req,
    input  tag_exp_en, tag_exp_addr, exp_ready,
    output lk_ready, fl_ready, inv_ready, busy,
    output tag_read_clkEn, tag_read_addr, tag_write_addr, tag_write_wen,
    output tag_invalidate, tag_init, exp_valid, exp_addr
  );

  modport master (
    output lk_valid, lk_addr, fl_valid, fl_addr, inv_valid, inv_addr, flush_req,
    output tag_exp_en, tag_exp_addr, exp_ready,
    input  lk_ready, fl_ready, inv_ready, busy,
    input  tag_read_clkEn, tag_read_addr, tag_write_addr, tag_write_wen,
    input  tag_invalidate, tag_init, exp_valid, exp_addr
  );
endinterface

// File: rtl/cc_tag_ctl.sv
// Sequencer/arbiter in front of one cc1 tag array bank.
//   - Runs the post-reset init sweep and on-demand flush sweeps over every set.
//   - Arbitrates the single tag write port between snoop invalidates and fills, with a
//     starvation guard for fills, and gates lookups while a sweep is pending or running.
//   - Captures expunged victim addresses into a small FIFO toward writeback.
// Ports:
//   clk  clock; state updates on the falling edge to line up with the tag array
//   rst  asynchronous active-low reset
//   bus  cc_tag_ctl_if.slave (lookup, fill, invalidate, flush, tag array, expunge stream)
module cc_tag_ctl #(
`ifdef ICACHE_256K
  parameter int unsigned ADDR_WIDTH = 8,
`else
  parameter int unsigned ADDR_WIDTH = 7,
`endif
  parameter int unsigned ADDR_COUNT = 2 ** ADDR_WIDTH,
  parameter int unsigned EXP_DEPTH  = 4,
  parameter int unsigned STARVE_MAX = 7
) (
  input logic         clk,
  input logic         rst,
  cc_tag_ctl_if.slave bus
);

  localparam int unsigned PA      = 37;
  localparam int unsigned PtrW    = $clog2(EXP_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StInit, StRun, StFlush, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  sweep_q, sweep_d;
  logic [StarveW-1:0]     starve_q, starve_d;
  logic [1:0]             pend_q, pend_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PA-1:0]          mem_q [EXP_DEPTH];

  logic room, inv_ok, fl_ok, fl_gnt, inv_gnt, wr_gnt;
  logic resp, push, pop;

  // Every grant reserves a FIFO slot until its expunge response has been seen, so a
  // push into a full FIFO is impossible.
  assign room = (32'(cnt_q) + 32'(pend_q)) < EXP_DEPTH;

  always_comb begin
    state_d             = state_q;
    sweep_d             = sweep_q;
    starve_d            = starve_q;
    fl_gnt              = 1'b0;
    inv_gnt             = 1'b0;
    inv_ok              = 1'b0;
    fl_ok               = 1'b0;
    bus.busy            = 1'b0;
    bus.lk_ready        = 1'b0;
    bus.fl_ready        = 1'b0;
    bus.inv_ready       = 1'b0;
    bus.tag_read_clkEn  = 1'b0;
    bus.tag_read_addr   = '0;
    bus.tag_write_addr  = '0;
    bus.tag_write_wen   = 1'b0;
    bus.tag_invalidate  = 1'b0;
    bus.tag_init        = 1'b0;

    unique case (state_q)
      StInit, StFlush: begin
        bus.busy           = 1'b1;
        // Held low during reset so the array is not initialised while rst is asserted.
        bus.tag_init       = rst;
        bus.tag_write_addr = PA'(sweep_q);
        if (sweep_q == ADDR_WIDTH'(ADDR_COUNT - 1)) begin
          state_d = StRun;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end

      StRun: begin
        bus.lk_ready       = 1'b1;
        bus.tag_read_clkEn = bus.lk_valid;
        bus.tag_read_addr  = bus.lk_addr;
        if (bus.flush_req) begin
          state_d = StDrain;
        end else begin
          inv_ok  = bus.inv_valid & room;
          fl_ok   = bus.fl_valid & room;
          // Fill normally yields to invalidates, but a starved fill is forced through.
          fl_gnt  = fl_ok & (~inv_ok | (starve_q == StarveW'(STARVE_MAX)));
          inv_gnt = inv_ok & ~fl_gnt;
        end
        bus.fl_ready       = fl_gnt;
        bus.inv_ready      = inv_gnt;
        bus.tag_write_wen  = fl_gnt;
        bus.tag_invalidate = inv_gnt;
        if (fl_gnt) begin
          bus.tag_write_addr = bus.fl_addr;
        end else if (inv_gnt) begin
          bus.tag_write_addr = bus.inv_addr;
        end
        if (fl_gnt) begin
          starve_d = '0;
        end else if (bus.fl_valid && (starve_q != StarveW'(STARVE_MAX))) begin
          starve_d = starve_q + 1'b1;
        end
      end

      StDrain: begin
        bus.busy = 1'b1;
        // The last write's expunge must be captured before init wipes the tags.
        if (pend_q == '0) begin
          state_d  = StFlush;
          starve_d = '0;
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Expunge capture: the cycle after a write grant is the response cycle.
  assign wr_gnt        = fl_gnt | inv_gnt;
  assign resp          = (pend_q != '0);
  assign push          = resp & bus.tag_exp_en;
  assign pop           = (cnt_q != '0) & bus.exp_ready;
  assign pend_d        = pend_q + {1'b0, wr_gnt} - {1'b0, resp};
  assign cnt_d         = cnt_q + CntW'(push) - CntW'(pop);
  assign wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign bus.exp_valid = (cnt_q != '0);
  assign bus.exp_addr  = bus.exp_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StInit;
      sweep_q  <= '0;
      starve_q <= '0;
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage only; validity is tracked by cnt_q, so no reset is needed.
  always_ff @(negedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tag_exp_addr;
    end
  end

endmodule
